// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - shared opcodes and sequencer state encoding for the calculator driver
package calc_pkg;

    localparam logic [2:0] OP_SRL  = 3'b000;
    localparam logic [2:0] OP_SLL  = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_MUL  = 3'b100;
    localparam logic [2:0] OP_NOR  = 3'b101;
    localparam logic [2:0] OP_NAND = 3'b110;
    localparam logic [2:0] OP_XOR  = 3'b111;

    // bit of cmd_op that turns the command into an accumulator clear
    localparam int CMD_CLR = 3;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_PULSE  = 3'd2,
        ST_SETTLE = 3'd3,
        ST_RESP   = 3'd4
    } state_t;

endpackage

// File: rtl/calc_cmd_sequencer_if.sv
// rtl/calc_cmd_sequencer_if.sv - command/response handshake bundle for the calculator sequencer
interface calc_cmd_sequencer_if #(parameter int OLD_SIZE = 16);

    logic                cmd_valid;
    logic                cmd_ready;
    logic [3:0]          cmd_op;
    logic [OLD_SIZE-1:0] cmd_operand;
    logic [OLD_SIZE-1:0] cmd_expect;
    logic                cmd_check;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [OLD_SIZE-1:0] rsp_data;
    logic                rsp_mismatch;

    modport master (
        output cmd_valid, cmd_op, cmd_operand, cmd_expect, cmd_check, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_data, rsp_mismatch
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_operand, cmd_expect, cmd_check, rsp_ready,
        output cmd_ready, rsp_valid, rsp_data, rsp_mismatch
    );

endinterface

// File: rtl/calc_cmd_fifo.sv
// rtl/calc_cmd_fifo.sv - synchronous command FIFO, power-of-two depth
module calc_cmd_fifo #(
    parameter int WIDTH = 37,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign rdata   = mem[rptr];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr] <= wdata;
        end
    end

    // pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/calc_cmd_sequencer.sv
// rtl/calc_cmd_sequencer.sv - replays queued commands onto the calculator buttons and returns led results
module calc_cmd_sequencer
    import calc_pkg::*;
#(
    parameter int OLD_SIZE   = 16,
    parameter int DEPTH      = 4,
    parameter int SETUP_CYC  = 1,
    parameter int PULSE_CYC  = 1,
    parameter int SETTLE_CYC = 2
) (
    input  logic                clk,
    input  logic                btnac,
    calc_cmd_sequencer_if.slave bus,
    output logic [OLD_SIZE-1:0] sw_out,
    output logic                btnl_out,
    output logic                btnr_out,
    output logic                btnd_out,
    output logic                btnc_out,
    output logic                ac_out,
    input  logic [OLD_SIZE-1:0] led_in,
    output logic [7:0]          err_count,
    output logic                busy
);

    localparam int WIDTH = 4 + 2*OLD_SIZE + 1;
    localparam logic [15:0] CNT_SETUP  = 16'(SETUP_CYC - 1);
    localparam logic [15:0] CNT_PULSE  = 16'(PULSE_CYC - 1);
    localparam logic [15:0] CNT_SETTLE = 16'(SETTLE_CYC - 1);

    state_t              state;
    state_t              state_nxt;
    logic [15:0]         cnt;
    logic                cnt_zero;
    logic                pop;
    logic                push;
    logic                fifo_full;
    logic                fifo_empty;
    logic [WIDTH-1:0]    fifo_rdata;
    logic [3:0]          f_op;
    logic [OLD_SIZE-1:0] f_operand;
    logic [OLD_SIZE-1:0] f_expect;
    logic                f_check;
    logic                clr_q;
    logic                chk_q;
    logic [OLD_SIZE-1:0] exp_q;
    logic [OLD_SIZE-1:0] rsp_data_q;
    logic                mismatch_q;

    assign push      = bus.cmd_valid && bus.cmd_ready;
    assign f_op      = fifo_rdata[WIDTH-1 -: 4];
    assign f_operand = fifo_rdata[2*OLD_SIZE -: OLD_SIZE];
    assign f_expect  = fifo_rdata[OLD_SIZE -: OLD_SIZE];
    assign f_check   = fifo_rdata[0];
    assign cnt_zero  = (cnt == '0);

    calc_cmd_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (btnac),
        .push  (push),
        .pop   (pop),
        .wdata ({bus.cmd_op, bus.cmd_operand, bus.cmd_expect, bus.cmd_check}),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (btnac) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (!fifo_empty)   state_nxt = ST_SETUP;
            ST_SETUP:  if (cnt_zero)      state_nxt = ST_PULSE;
            ST_PULSE:  if (cnt_zero)      state_nxt = ST_SETTLE;
            ST_SETTLE: if (cnt_zero)      state_nxt = ST_RESP;
            ST_RESP:   if (bus.rsp_ready) state_nxt = ST_IDLE;
            default:                      state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        pop           = (state == ST_IDLE) && !fifo_empty;
        btnc_out      = (state == ST_PULSE) && !clr_q;
        ac_out        = (state == ST_PULSE) && clr_q;
        bus.rsp_valid = (state == ST_RESP);
    end

    assign busy             = (state != ST_IDLE) || !fifo_empty;
    assign bus.cmd_ready    = !fifo_full;
    assign bus.rsp_data     = rsp_data_q;
    assign bus.rsp_mismatch = mismatch_q;

    // one down-counter is reloaded on every phase entry and shared by SETUP/PULSE/SETTLE
    always_ff @(posedge clk) begin
        if (btnac) begin
            cnt        <= '0;
            clr_q      <= 1'b0;
            chk_q      <= 1'b0;
            exp_q      <= '0;
            sw_out     <= '0;
            btnl_out   <= 1'b0;
            btnr_out   <= 1'b0;
            btnd_out   <= 1'b0;
            rsp_data_q <= '0;
            mismatch_q <= 1'b0;
            err_count  <= '0;
        end else begin
            if (state_nxt != state) begin
                case (state_nxt)
                    ST_SETUP:  cnt <= CNT_SETUP;
                    ST_PULSE:  cnt <= CNT_PULSE;
                    ST_SETTLE: cnt <= CNT_SETTLE;
                    default:   cnt <= '0;
                endcase
            end else if (!cnt_zero) begin
                cnt <= cnt - 1'b1;
            end

            if (pop) begin
                clr_q  <= f_op[CMD_CLR];
                chk_q  <= f_check;
                exp_q  <= f_expect;
                sw_out <= f_op[CMD_CLR] ? '0 : f_operand;
                {btnl_out, btnr_out, btnd_out} <= f_op[CMD_CLR] ? 3'b000 : f_op[2:0];
            end

            if (state == ST_SETTLE && cnt_zero) begin
                rsp_data_q <= led_in;
                mismatch_q <= chk_q && (led_in != exp_q);
            end

            if (state == ST_RESP && bus.rsp_ready && mismatch_q && err_count != 8'hff) begin
                err_count <= err_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_calc_cmd_sequencer.sv
// tb/tb_calc_cmd_sequencer.sv - self-checking bench with calculator model and response scoreboard
module tb_calc_cmd_sequencer;
    import calc_pkg::*;

    localparam int W     = 16;
    localparam int DEPTH = 4;

    logic         clk = 1'b0;
    logic         btnac;
    logic [W-1:0] sw_out;
    logic [W-1:0] led_in;
    logic         btnl_out, btnr_out, btnd_out, btnc_out, ac_out;
    logic [7:0]   err_count;
    logic         busy;

    always #5 clk = ~clk;

    calc_cmd_sequencer_if #(.OLD_SIZE(W)) bus ();

    calc_cmd_sequencer #(.OLD_SIZE(W), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .btnac     (btnac),
        .bus       (bus.slave),
        .sw_out    (sw_out),
        .btnl_out  (btnl_out),
        .btnr_out  (btnr_out),
        .btnd_out  (btnd_out),
        .btnc_out  (btnc_out),
        .ac_out    (ac_out),
        .led_in    (led_in),
        .err_count (err_count),
        .busy      (busy)
    );

    function automatic logic [W-1:0] alu(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        case (op)
            OP_SRL:  return a >> b;
            OP_SLL:  return a << b;
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_MUL:  return a * b;
            OP_NOR:  return ~(a | b);
            OP_NAND: return ~(a & b);
            default: return a ^ b;
        endcase
    endfunction

    // calculator under control: acts on the rising edge of btnc, cleared by btnac
    logic [W-1:0] calc_acc;
    logic         btnc_d;
    assign led_in = calc_acc;
    always_ff @(posedge clk) begin
        if (btnac || ac_out) calc_acc <= '0;
        else if (btnc_out && !btnc_d) calc_acc <= alu({btnl_out, btnr_out, btnd_out}, calc_acc, sw_out);
        btnc_d <= btnc_out;
    end

    int           tests = 0;
    int           fails = 0;
    logic [W-1:0] m_acc = '0;
    int           m_err = 0;
    logic [W-1:0] exp_data_q [$];
    logic         exp_mis_q  [$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W-1:0] predict(input logic [3:0] op, input logic [W-1:0] opnd);
        return op[CMD_CLR] ? '0 : alu(op[2:0], m_acc, opnd);
    endfunction

    task automatic model_push(input logic [3:0] op, input logic [W-1:0] opnd, input logic [W-1:0] ex, input logic ck);
        m_acc = predict(op, opnd);
        exp_data_q.push_back(m_acc);
        exp_mis_q.push_back(ck && (ex != m_acc));
    endtask

    task automatic send(input logic [3:0] op, input logic [W-1:0] opnd, input logic [W-1:0] ex, input logic ck);
        int n = 0;
        bus.cmd_op = op; bus.cmd_operand = opnd; bus.cmd_expect = ex; bus.cmd_check = ck;
        bus.cmd_valid = 1'b1;
        while (!bus.cmd_ready && n < 100) begin tick; n++; end
        chk("cmd_ready", bus.cmd_ready, 1);
        tick;
        bus.cmd_valid = 1'b0;
        model_push(op, opnd, ex, ck);
    endtask

    task automatic recv(input int delay);
        int n = 0;
        logic [W-1:0] d;
        logic m;
        while (!bus.rsp_valid && n < 200) begin tick; n++; end
        chk("rsp_valid", bus.rsp_valid, 1);
        if (bus.rsp_valid && exp_data_q.size() > 0) begin
            d = exp_data_q.pop_front();
            m = exp_mis_q.pop_front();
            chk("rsp_data", bus.rsp_data, d);
            chk("rsp_mismatch", bus.rsp_mismatch, m);
            repeat (delay) begin
                tick;
                chk("rsp_hold", {bus.rsp_valid, bus.rsp_data}, {1'b1, d});
            end
            bus.rsp_ready = 1'b1;
            tick;
            bus.rsp_ready = 1'b0;
            if (m && m_err < 255) m_err++;
            chk("err_count", err_count, m_err);
        end
    endtask

    task automatic do_cmd(input logic [3:0] op, input logic [W-1:0] opnd, input logic [W-1:0] ex, input logic ck, input int delay);
        send(op, opnd, ex, ck);
        recv(delay);
    endtask

    logic [3:0]   chain_op  [8] = '{{1'b0, OP_ADD}, {1'b0, OP_XOR}, {1'b0, OP_SRL}, {1'b0, OP_NOR},
                                    {1'b0, OP_MUL}, {1'b0, OP_SLL}, {1'b0, OP_NAND}, {1'b0, OP_SUB}};
    logic [W-1:0] chain_arg [8] = '{16'h285a, 16'h04c8, 16'h0005, 16'ha085, 16'h07fe, 16'h0004, 16'hfa65, 16'hb2e4};
    logic [W-1:0] chain_res [8] = '{16'h285a, 16'h2c92, 16'h0164, 16'h5e1a, 16'h13cc, 16'h3cc0, 16'hc7bf, 16'h14db};

    initial begin
        logic [3:0]   op;
        logic [W-1:0] opnd, ex, held;
        logic         ck, go, saw_full, have;
        int           n, idx;

        btnac = 1'b1;
        bus.cmd_valid = 1'b0; bus.cmd_op = '0; bus.cmd_operand = '0;
        bus.cmd_expect = '0; bus.cmd_check = 1'b0; bus.rsp_ready = 1'b0;
        repeat (3) tick;
        btnac = 1'b0;
        chk("rst_outputs", {bus.rsp_valid, busy, btnc_out, ac_out, btnl_out, btnr_out, btnd_out},
            7'b0);
        chk("rst_err_count", err_count, 0);
        chk("rst_sw_out", sw_out, 0);
        chk("rst_rsp_data", bus.rsp_data, 0);

        // latency from pop: push into empty FIFO, pop happens in the following cycle
        bus.cmd_op = {1'b0, OP_ADD}; bus.cmd_operand = 16'h285a; bus.cmd_expect = 16'h285a;
        bus.cmd_check = 1'b1; bus.cmd_valid = 1'b1;
        tick;
        bus.cmd_valid = 1'b0;
        model_push({1'b0, OP_ADD}, 16'h285a, 16'h285a, 1'b1);
        n = 0;
        while (!btnc_out && n < 20) begin tick; n++; end
        chk("btnc_latency", n, 2);
        while (!bus.rsp_valid && n < 20) begin tick; n++; end
        chk("rsp_latency", n, 5);
        recv(0);

        do_cmd(4'b1000, 16'hffff, 16'h0000, 1'b1, 1);
        do_cmd({1'b0, OP_ADD}, 16'h285a, 16'h285a, 1'b1, 0);

        do_cmd(4'b1000, 16'h0000, 16'h0000, 1'b0, 0);
        for (int i = 0; i < 8; i++) do_cmd(chain_op[i], chain_arg[i], chain_res[i], 1'b1, i % 3);
        chk("chain_err_count", err_count, 0);

        for (int i = 0; i < 40; i++) begin
            op = 4'($urandom_range(0, 7));
            if ($urandom_range(0, 7) == 0) op[CMD_CLR] = 1'b1;
            opnd = (op[2:1] == 2'b00) ? W'($urandom_range(0, W)) : W'($urandom);
            ck = 1'($urandom);
            ex = $urandom_range(0, 1) ? predict(op, opnd) : W'($urandom);
            do_cmd(op, opnd, ex, ck, $urandom_range(0, 3));
        end

        // response back-pressure: FIFO fills while one command waits in RESP
        idx = 0; saw_full = 1'b0; have = 1'b0; held = '0;
        for (int c = 0; c < 20; c++) begin
            bus.cmd_op = {1'b0, OP_ADD}; bus.cmd_operand = W'((idx + 1) * 16'h0111);
            bus.cmd_expect = '0; bus.cmd_check = 1'b0;
            bus.cmd_valid = (idx < 6);
            go = bus.cmd_valid && bus.cmd_ready;
            if (!bus.cmd_ready) saw_full = 1'b1;
            if (have) begin
                chk("rsp_stable", bus.rsp_data, held);
                chk("no_pulse_in_resp", btnc_out, 0);
            end else if (bus.rsp_valid) begin
                held = bus.rsp_data;
                have = 1'b1;
            end
            tick;
            if (go) begin
                model_push({1'b0, OP_ADD}, W'((idx + 1) * 16'h0111), '0, 1'b0);
                idx++;
            end
        end
        bus.cmd_valid = 1'b0;
        chk("bp_accepted", idx, DEPTH + 1);
        chk("bp_saw_full", saw_full, 1);
        chk("bp_ready_low", bus.cmd_ready, 0);
        chk("bp_rsp_seen", have, 1);
        repeat (idx) recv(0);
        do_cmd({1'b0, OP_ADD}, 16'h0666, 16'h0000, 1'b0, 0);

        // reset while a pulse is on the wire with more commands queued
        send({1'b0, OP_ADD}, 16'h0005, 16'h0, 1'b0);
        send({1'b0, OP_ADD}, 16'h0006, 16'h0, 1'b0);
        send({1'b0, OP_ADD}, 16'h0007, 16'h0, 1'b0);
        n = 0;
        while (!btnc_out && n < 20) begin tick; n++; end
        chk("pulse_seen", btnc_out, 1);
        btnac = 1'b1;
        tick;
        btnac = 1'b0;
        chk("midrst_strobes", {btnc_out, ac_out, bus.rsp_valid, busy}, 4'b0);
        chk("midrst_err_count", err_count, 0);
        chk("midrst_sw_out", sw_out, 0);
        exp_data_q.delete();
        exp_mis_q.delete();
        m_acc = '0;
        m_err = 0;
        repeat (8) tick;
        chk("midrst_idle", {busy, bus.rsp_valid}, 2'b0);
        do_cmd({1'b0, OP_ADD}, 16'h00aa, 16'h00aa, 1'b1, 0);

        // mismatch counting and saturation
        do_cmd(4'b1000, 16'h0000, 16'h0000, 1'b0, 0);
        do_cmd({1'b0, OP_ADD}, 16'h0001, 16'h1234, 1'b1, 0);
        chk("first_mismatch_count", err_count, 1);
        for (int i = 0; i < 299; i++) begin
            ex = predict({1'b0, OP_ADD}, 16'h0001) ^ 16'h1234;
            do_cmd({1'b0, OP_ADD}, 16'h0001, ex, 1'b1, 0);
        end
        chk("err_count_saturated", err_count, 255);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/calc_cmd_sequencer.md
Name: calc_cmd_sequencer

Overview:
- Master-side driver for the accumulator calculator's button/switch interface.
- Accepts queued commands (opcode, operand, optional expected result) over a valid/ready port.
- Replays each command onto the calculator's sw/btnl/btnr/btnd/btnc/btnac inputs with defined setup, pulse and settle timing.
- Samples the calculator's led output and returns it as a response, with a compare-against-expected result.
- Used for scripted self-test on the board and as the stimulus engine in calculator benches.

Parameters:
- OLD_SIZE, 16, data width of operand, sw_out and led_in.
- DEPTH, 4, command FIFO entries; power of two, minimum 2.
- SETUP_CYC, 1, cycles sw/op lines are held stable before the btnc pulse (minimum 1).
- PULSE_CYC, 1, cycles btnc_out (or ac_out) is held high (minimum 1).
- SETTLE_CYC, 2, cycles after pulse release before led_in is sampled (minimum 1).

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- btnac  in  1  reset, synchronous, active-high.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  FIFO not full.
- cmd_op  in  4  [3]=clear, [2:0]={btnl,btnr,btnd} opcode.
- cmd_operand  in  OLD_SIZE  value driven on sw_out.
- cmd_expect  in  OLD_SIZE  expected led value.
- cmd_check  in  1  compare enable.
- sw_out  out  OLD_SIZE  to calculator sw.
- btnl_out / btnr_out / btnd_out  out  1 each  to calculator op-select buttons.
- btnc_out  out  1  to calculator btnc.
- ac_out  out  1  to calculator btnac.
- led_in  in  OLD_SIZE  calculator accumulator.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response accepted.
- rsp_data  out  OLD_SIZE  sampled led_in.
- rsp_mismatch  out  1  cmd_check set and rsp_data != cmd_expect.
- err_count  out  8  saturating mismatch count.
- busy  out  1  FSM not in IDLE or FIFO not empty.

Behaviour:
- Opcode map {l,r,d}, per calculator:
  - 000 shift right logical, 001 shift left logical.
  - 010 add, 011 subtract.
  - 100 multiply (low OLD_SIZE bits), 101 NOR, 110 NAND, 111 XOR.
- Reset (btnac=1 at an edge):
  - FIFO emptied; FSM to IDLE.
  - All outputs 0 on the following edge, including rsp_valid, err_count, btnc_out and ac_out.
  - Applies mid-operation: an active pulse is dropped and any pending response is discarded.
- FIFO:
  - Push when cmd_valid && cmd_ready. cmd_ready = !full; it is low at DEPTH entries even if a pop occurs in the same cycle.
  - Pointers wrap modulo DEPTH.
  - A push into an empty FIFO is poppable on the next cycle.
- FSM:
  - IDLE: if FIFO non-empty, pop the head; latch op/operand/expect/check; drive sw_out and btnl/r/d_out from the latched command (clear commands drive 0); go to SETUP.
  - SETUP: hold outputs for SETUP_CYC cycles; then go to PULSE.
  - PULSE: for PULSE_CYC cycles, btnc_out=1 (normal op) or ac_out=1 (clear, op[3]=1; btnc_out stays 0); then go to SETTLE.
  - SETTLE: strobes low; count SETTLE_CYC cycles. On the final cycle, capture led_in into rsp_data and compute rsp_mismatch; go to RESP.
  - RESP: rsp_valid=1 and held with stable data until rsp_ready. On the handshake edge: if mismatch, err_count increments, saturating at 255; then go to IDLE.
- sw_out and btnl/r/d_out hold the last command's values until the next IDLE pop.
- One command is outstanding at a time. Minimum command latency from pop to rsp_valid = 1 + SETUP_CYC + PULSE_CYC + SETTLE_CYC cycles.
- Clear commands are never compared against 0 implicitly; compare only when cmd_check=1.
- rsp_ready may be held high permanently; RESP then lasts exactly one cycle.

Decomposition:
- Shared package calc_pkg:
  - opcode localparams (OP_SRL, OP_SLL, OP_ADD, OP_SUB, OP_MUL, OP_NOR, OP_NAND, OP_XOR, CMD_CLR bit index);
  - FSM state encoding (ST_IDLE, ST_SETUP, ST_PULSE, ST_SETTLE, ST_RESP).
- Sub-module calc_cmd_fifo: synchronous FIFO, width 4+2*OLD_SIZE+1, parameter DEPTH, push/pop/full/empty.
- The sequencer instantiates calc_cmd_fifo and a shared down-counter for the three timed phases.

Test Plan:
- Connect to calculator. Push clear, then add 0x285a with expect 0x285a, check=1 -> two responses; rsp_data 0x0000 then 0x285a; mismatch 0; err_count 0.
- Full chain after clear: add 285a, xor 04c8, srl 0005, nor a085, mul 07fe, sll 0004, nand fa65, sub b2e4 -> rsp_data 285a, 2c92, 0164, 5e1a, 13cc, 3cc0, c7bf, 14db; all mismatch 0.
- Expect 0x1234 on add 0x0001 from 0 -> rsp_mismatch=1, err_count=1 after handshake. Repeat 300 times -> err_count saturates at 255.
- Hold rsp_ready=0 for 20 cycles and push 6 commands -> cmd_ready falls after DEPTH accepted; rsp_data stable; no btnc_out pulse issued while in RESP.
- Assert btnac during PULSE -> next edge btnc_out=0, rsp_valid=0, busy=0, FIFO empty; subsequent command is processed normally.
- Measure defaults -> btnc_out rises exactly 2 cycles after pop; rsp_valid rises exactly 5 cycles after pop.
